// File: rtl/dmem_pkg.sv
// Shared types and sizes for the dmem_responder slice.
// Optional feature macro used by the top: DMEM_ALIGN_CHECK_EN.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BEAT_W     = $clog2(WORD_BYTES);
  localparam int unsigned WAIT_W     = 4;

endpackage

// File: rtl/dmem_byte_ram.sv
// Byte-wide single-port RAM: synchronous write, combinational read.
module dmem_byte_ram #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side load/store responder: byte/word requests served over byte beats.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned word accesses with rsp_err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_word,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : WAIT_W'(WAIT_CYCLES - 1);

  state_e              state_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [WAIT_W-1:0]   wait_q;
  logic                write_q;
  logic                word_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;

  logic [BEAT_W-1:0]   last_beat_c;
  logic [ADDR_W-1:0]   ram_addr_c;
  logic [7:0]          ram_wdata_c;
  logic [7:0]          ram_rdata_c;
  logic                ram_we_c;
  logic                misalign_c;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign_c = req_word && (req_addr[1:0] != 2'b00);
`else
  assign misalign_c = 1'b0;
`endif

  assign last_beat_c = word_q ? BEAT_W'(WORD_BYTES - 1) : '0;
  assign ram_addr_c  = addr_q + ADDR_W'(beat_q);
  assign ram_wdata_c = wdata_q[{beat_q, 3'b000} +: 8];
  // A reset landing on a beat must not commit that beat's byte.
  assign ram_we_c    = (state_q == XFER) && write_q && !rst;

  dmem_byte_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we_c),
    .addr  (ram_addr_c),
    .wdata (ram_wdata_c),
    .rdata (ram_rdata_c)
  );

  // FSM, request capture and response assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      beat_q    <= '0;
      wait_q    <= '0;
      write_q   <= 1'b0;
      word_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            write_q   <= req_write;
            word_q    <= req_word;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            rsp_rdata <= '0;
            rsp_err   <= misalign_c;
            beat_q    <= '0;
            wait_q    <= WAIT_LOAD;
            // An error response spends its single cycle of latency in WAIT.
            if (misalign_c || (WAIT_CYCLES != 0)) state_q <= WAIT;
            else                                  state_q <= XFER;
          end
        end
        WAIT: begin
          if (rsp_err) begin
            state_q   <= RESP;
            rsp_valid <= 1'b1;
          end else if (wait_q == '0) begin
            state_q <= XFER;
          end else begin
            wait_q <= wait_q - WAIT_W'(1);
          end
        end
        XFER: begin
          if (!write_q) rsp_rdata[{beat_q, 3'b000} +: 8] <= ram_rdata_c;
          if (beat_q == last_beat_c) begin
            state_q   <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            beat_q <= beat_q + BEAT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q   <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (WAIT_CYCLES=2).
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned WAIT_CYCLES = 2;
  localparam int          LAT_BYTE    = WAIT_CYCLES + 1;
  localparam int          LAT_WORD    = WAIT_CYCLES + 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_word;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_word  (req_word),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  typedef struct {
    string       name;
    logic        w;
    logic        wd;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          hold;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Runs one request/response; called and returns at 1ns after a rising edge.
  task automatic xact(input string name, input logic w, input logic wd, input logic [7:0] a,
                      input logic [31:0] d, input int hold, input logic [31:0] exp_rd,
                      input logic exp_err, input int exp_lat);
    int          lat;
    logic        busy_ok;
    logic        stable;
    logic [31:0] rd0;
    logic        er0;
    check({name, " ready before accept"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_word = wd; req_addr = a; req_wdata = d;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    // Scramble request inputs: the DUT must use the captured copy.
    req_valid = 1'b0; req_write = ~w; req_word = ~wd; req_addr = ~a; req_wdata = ~d;
    lat = 0;
    busy_ok = 1'b1;
    while (!rsp_valid && lat < 64) begin
      if (req_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (req_ready) busy_ok = 1'b0;
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " req_ready low while busy"}, 32'(busy_ok), 32'd1);
    check({name, " rdata"}, rsp_rdata, exp_rd);
    check({name, " err"}, 32'(rsp_err), 32'(exp_err));
    rd0 = rsp_rdata; er0 = rsp_err; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_rdata !== rd0 || rsp_err !== er0 || req_ready) stable = 1'b0;
    end
    if (hold > 0) check({name, " response held"}, 32'(stable), 32'd1);
    // Offer a new request in the handshake cycle; it must not be taken.
    rsp_ready = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_word = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b0;
    check({name, " rsp_valid after handshake"}, 32'(rsp_valid), 32'd0);
    check({name, " req_ready after handshake"}, 32'(req_ready), 32'd1);
  endtask

  vec_t tbl[13];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic seen;
    tbl[0]  = '{"st_w10",  1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 0, 32'h0,        1'b0, LAT_WORD};
    tbl[1]  = '{"ld_b10",  1'b0, 1'b0, 8'h10, 32'h0,        0, 32'h000000EF, 1'b0, LAT_BYTE};
    tbl[2]  = '{"ld_b11",  1'b0, 1'b0, 8'h11, 32'h0,        0, 32'h000000BE, 1'b0, LAT_BYTE};
    tbl[3]  = '{"ld_b12",  1'b0, 1'b0, 8'h12, 32'h0,        0, 32'h000000AD, 1'b0, LAT_BYTE};
    tbl[4]  = '{"ld_b13",  1'b0, 1'b0, 8'h13, 32'h0,        0, 32'h000000DE, 1'b0, LAT_BYTE};
    tbl[5]  = '{"ld_w10h", 1'b0, 1'b1, 8'h10, 32'h0,        3, 32'hDEADBEEF, 1'b0, LAT_WORD};
    tbl[6]  = '{"st_b12",  1'b1, 1'b0, 8'h12, 32'hCAFE0077, 0, 32'h0,        1'b0, LAT_BYTE};
    tbl[7]  = '{"ld_w10b", 1'b0, 1'b1, 8'h10, 32'h0,        1, 32'hDE77BEEF, 1'b0, LAT_WORD};
    tbl[8]  = '{"st_w20",  1'b1, 1'b1, 8'h20, 32'h44332211, 0, 32'h0,        1'b0, LAT_WORD};
    tbl[9]  = '{"st_w24",  1'b1, 1'b1, 8'h24, 32'h88776655, 0, 32'h0,        1'b0, LAT_WORD};
    tbl[10] = '{"st_w40",  1'b1, 1'b1, 8'h40, 32'h11223344, 0, 32'h0,        1'b0, LAT_WORD};
    tbl[11] = '{"ld_b21",  1'b0, 1'b0, 8'h21, 32'h0,        0, 32'h00000022, 1'b0, LAT_BYTE};
    tbl[12] = '{"ld_b27",  1'b0, 1'b0, 8'h27, 32'h0,        2, 32'h00000088, 1'b0, LAT_BYTE};

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_word = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset rsp_err",   32'(rsp_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++)
      xact(tbl[i].name, tbl[i].w, tbl[i].wd, tbl[i].addr, tbl[i].wdata, tbl[i].hold,
           tbl[i].exp_rd, tbl[i].exp_err, tbl[i].exp_lat);

`ifdef DMEM_ALIGN_CHECK_EN
    // Misaligned word accesses are rejected and leave memory untouched.
    xact("st_bFE",   1'b1, 1'b0, 8'hFE, 32'h00000055, 0, 32'h0, 1'b0, LAT_BYTE);
    xact("st_wFE",   1'b1, 1'b1, 8'hFE, 32'h04030201, 0, 32'h0, 1'b1, 1);
    xact("ld_bFE",   1'b0, 1'b0, 8'hFE, 32'h0,        0, 32'h00000055, 1'b0, LAT_BYTE);
    xact("ld_w21",   1'b0, 1'b1, 8'h21, 32'h0,        2, 32'h0, 1'b1, 1);
`else
    // Misaligned word accesses wrap around the top of memory.
    xact("st_wFE",   1'b1, 1'b1, 8'hFE, 32'h04030201, 0, 32'h0, 1'b0, LAT_WORD);
    xact("ld_bFE",   1'b0, 1'b0, 8'hFE, 32'h0, 0, 32'h00000001, 1'b0, LAT_BYTE);
    xact("ld_bFF",   1'b0, 1'b0, 8'hFF, 32'h0, 0, 32'h00000002, 1'b0, LAT_BYTE);
    xact("ld_b00",   1'b0, 1'b0, 8'h00, 32'h0, 0, 32'h00000003, 1'b0, LAT_BYTE);
    xact("ld_b01",   1'b0, 1'b0, 8'h01, 32'h0, 0, 32'h00000004, 1'b0, LAT_BYTE);
    xact("ld_wFE",   1'b0, 1'b1, 8'hFE, 32'h0, 0, 32'h04030201, 1'b0, LAT_WORD);
    xact("ld_w21",   1'b0, 1'b1, 8'h21, 32'h0, 0, 32'h55443322, 1'b0, LAT_WORD);
`endif

    // Reset during beat 2 of a word store: beats 0 and 1 stay committed.
    check("abort ready before accept", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = 1'b1; req_word = 1'b1;
    req_addr = 8'h40; req_wdata = 32'hAABBCCDD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort req_ready", 32'(req_ready), 32'd1);
    check("abort rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort rsp_rdata", rsp_rdata, 32'd0);
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    check("abort no response", 32'(seen), 32'd0);
    xact("ab_ld40", 1'b0, 1'b0, 8'h40, 32'h0, 0, 32'h000000DD, 1'b0, LAT_BYTE);
    xact("ab_ld41", 1'b0, 1'b0, 8'h41, 32'h0, 0, 32'h000000CC, 1'b0, LAT_BYTE);
    xact("ab_ld42", 1'b0, 1'b0, 8'h42, 32'h0, 0, 32'h00000022, 1'b0, LAT_BYTE);
    xact("ab_ld43", 1'b0, 1'b0, 8'h43, 32'h0, 0, 32'h00000011, 1'b0, LAT_BYTE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
